jk_excitation_counter: RTL and testbench

Modulo-N up/down counter whose state register is built from WIDTH JK flip-flop cells. Excitation logic computes each cell's J/K inputs from the desired next state: J = ~q & nxt, K = q & ~nxt. This is the inverse of the JK characteristic equation.
Includes a valid/ready parallel-load port, a terminal-count pulse and a saturating wrap counter. Serves as the sequencing element for the flip-flop conversion series.

---
 rtl/jk_excitation_counter.sv | 155 +++++++++++++++
 tb/tb_jk_excitation_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_counter.sv
// Modulo-MOD_MAX up/down counter whose state lives in WIDTH JK cells driven by excitation logic.
// Optional build macro JK_GRAY_CODE_EN makes the cells hold the Gray encoding of the count.
module jk_excitation_counter #(
   parameter int WIDTH   = 4,
   parameter int MOD_MAX = 10,
   parameter int WRAP_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up_dn,
   input  logic              ld_valid,
   input  logic [WIDTH-1:0]  ld_data,
   output logic              ld_ready,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  q_bar,
   output logic [WIDTH-1:0]  j_vec,
   output logic [WIDTH-1:0]  k_vec,
   output logic              tc,
   output logic [WRAP_W-1:0] wrap_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD_MAX - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD_MAX);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] ld_buf;
   logic [WIDTH-1:0] ld_clamped;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] j_exc;
   logic [WIDTH-1:0] k_exc;
   logic             handshake;
   logic             count_act;
   logic             wrap_evt;

   // Maps a binary count to the pattern the cells should hold.
   function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b);
`ifdef JK_GRAY_CODE_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

`ifdef JK_GRAY_CODE_EN
   function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign cnt = gray_to_bin(q_reg);
`else
   assign cnt = q_reg;
`endif

   assign handshake  = ld_valid & ld_ready;
   assign ld_clamped = ({1'b0, ld_data} >= MOD_EXT) ? LAST : ld_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A load handshake always wins over the count enable.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (handshake)   state_nxt = LOAD;
            else if (en)     state_nxt = RUN;
         end
         RUN: begin
            if (handshake)   state_nxt = LOAD;
            else if (!en)    state_nxt = IDLE;
         end
         LOAD: begin
            state_nxt = en ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ld_ready  = ~rst & (state != LOAD);
      count_act = (state == RUN) & en & ~handshake;
      cnt_nxt   = cnt;
      wrap_evt  = 1'b0;
      if (up_dn) begin
         cnt_nxt  = (cnt == LAST) ? '0 : cnt + WIDTH'(1);
         wrap_evt = count_act & (cnt == LAST);
      end else begin
         cnt_nxt  = (cnt == '0) ? LAST : cnt - WIDTH'(1);
         wrap_evt = count_act & (cnt == '0);
      end
   end

   // Target defaults to the present state so idle cells see J=K=0.
   always_comb begin
      target = q_reg;
      if (state == LOAD) begin
         target = encode(ld_buf);
      end else if (count_act) begin
         target = encode(cnt_nxt);
      end
      j_exc = ~q_reg & target;
      k_exc = q_reg & ~target;
   end

   // Each bit is a true JK cell: Qn = J & ~Q | ~K & Q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg <= '0;
      end else begin
         q_reg <= (j_exc & ~q_reg) | (~k_exc & q_reg);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_buf <= '0;
      end else if (handshake) begin
         ld_buf <= ld_clamped;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tc       <= 1'b0;
         wrap_cnt <= '0;
      end else begin
         tc <= wrap_evt;
         if (wrap_evt && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + WRAP_W'(1);
         end
      end
   end

   assign q     = q_reg;
   assign q_bar = ~q_reg;
   assign j_vec = j_exc;
   assign k_vec = k_exc;

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Directed self-checking bench for jk_excitation_counter; Gray sequence is checked when
// JK_GRAY_CODE_EN is defined, the binary scenarios otherwise.
module tb_jk_excitation_counter;

   localparam int WIDTH  = 4;
`ifdef JK_GRAY_CODE_EN
   localparam int MOD_MAX = 16;
`else
   localparam int MOD_MAX = 10;
`endif
   localparam int WRAP_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic              up_dn = 1'b1;
   logic              ld_valid = 1'b0;
   logic [WIDTH-1:0]  ld_data = '0;
   logic              ld_ready;
   logic [WIDTH-1:0]  q;
   logic [WIDTH-1:0]  q_bar;
   logic [WIDTH-1:0]  j_vec;
   logic [WIDTH-1:0]  k_vec;
   logic              tc;
   logic [WRAP_W-1:0] wrap_cnt;

   int errors = 0;
   int checks = 0;

   jk_excitation_counter #(.WIDTH(WIDTH), .MOD_MAX(MOD_MAX), .WRAP_W(WRAP_W)) dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_ready(ld_ready), .q(q), .q_bar(q_bar),
      .j_vec(j_vec), .k_vec(k_vec), .tc(tc), .wrap_cnt(wrap_cnt)
   );

   always #5 clk = ~clk;

   task tick();
      @(posedge clk);
      #1;
   endtask

   task do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; up_dn = 1'b1; ld_valid = 1'b0; ld_data = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task test_reset();
      #1 rst = 1'b1;
      #2;
      checks++; if (q !== 4'h0) begin errors++; $display("[TB] FAIL reset_q: got %h expected 0", q); end
      checks++; if (q_bar !== 4'hF) begin errors++; $display("[TB] FAIL reset_qbar: got %h expected f", q_bar); end
      checks++; if (tc !== 1'b0 || wrap_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_tc_wrap: got %b/%0d expected 0/0", tc, wrap_cnt); end
      checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ld_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (ld_ready !== 1'b1 || j_vec !== 4'h0 || k_vec !== 4'h0) begin errors++; $display("[TB] FAIL idle_outputs: got ready=%b j=%h k=%h expected 1/0/0", ld_ready, j_vec, k_vec); end
   endtask

   task test_count_up();
      do_reset();
      en = 1'b1; up_dn = 1'b1;
      tick();
      checks++; if (q !== 4'd0 || j_vec !== 4'b0001 || k_vec !== 4'b0000) begin errors++; $display("[TB] FAIL up_start: got q=%h j=%b k=%b expected 0/0001/0000", q, j_vec, k_vec); end
      for (int i = 1; i <= 9; i++) begin
         tick();
         checks++; if (q !== 4'(i) || tc !== 1'b0) begin errors++; $display("[TB] FAIL up_step: got q=%0d tc=%b expected %0d/0", q, tc, i); end
      end
      tick();
      checks++; if (q !== 4'd0 || tc !== 1'b1 || wrap_cnt !== 8'd1) begin errors++; $display("[TB] FAIL up_wrap: got q=%0d tc=%b wrap=%0d expected 0/1/1", q, tc, wrap_cnt); end
      tick();
      checks++; if (q !== 4'd1 || tc !== 1'b0) begin errors++; $display("[TB] FAIL up_after_wrap: got q=%0d tc=%b expected 1/0", q, tc); end
      up_dn = 1'b0;
      tick();
      checks++; if (q !== 4'd0 || tc !== 1'b0) begin errors++; $display("[TB] FAIL dir_change: got q=%0d tc=%b expected 0/0", q, tc); end
   endtask

   task test_count_down();
      do_reset();
      en = 1'b1; up_dn = 1'b0;
      tick();
      checks++; if (j_vec !== 4'b1001 || k_vec !== 4'b0000) begin errors++; $display("[TB] FAIL down_exc: got j=%b k=%b expected 1001/0000", j_vec, k_vec); end
      tick();
      checks++; if (q !== 4'd9 || q_bar !== 4'd6 || tc !== 1'b1 || wrap_cnt !== 8'd1) begin errors++; $display("[TB] FAIL down_wrap: got q=%0d qb=%h tc=%b wrap=%0d expected 9/6/1/1", q, q_bar, tc, wrap_cnt); end
      tick();
      checks++; if (q !== 4'd8 || tc !== 1'b0) begin errors++; $display("[TB] FAIL down_step: got q=%0d tc=%b expected 8/0", q, tc); end
   endtask

   task test_load();
      do_reset();
      en = 1'b1; up_dn = 1'b1;
      repeat (4) tick();
      ld_valid = 1'b1; ld_data = 4'd5;
      tick();
      ld_valid = 1'b0;
      checks++; if (q !== 4'd3 || ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_accept: got q=%0d ready=%b expected 3/0", q, ld_ready); end
      checks++; if (j_vec !== 4'b0100 || k_vec !== 4'b0010) begin errors++; $display("[TB] FAIL load_exc: got j=%b k=%b expected 0100/0010", j_vec, k_vec); end
      tick();
      checks++; if (q !== 4'd5 || ld_ready !== 1'b1 || tc !== 1'b0) begin errors++; $display("[TB] FAIL load_apply: got q=%0d ready=%b tc=%b expected 5/1/0", q, ld_ready, tc); end
      tick();
      checks++; if (q !== 4'd6) begin errors++; $display("[TB] FAIL load_resume: got q=%0d expected 6", q); end
      ld_valid = 1'b1; ld_data = 4'd12;
      tick();
      ld_valid = 1'b0;
      tick();
      checks++; if (q !== 4'd9 || tc !== 1'b0) begin errors++; $display("[TB] FAIL load_clamp: got q=%0d tc=%b expected 9/0", q, tc); end
      tick();
      checks++; if (q !== 4'd0 || tc !== 1'b1 || wrap_cnt !== 8'd1) begin errors++; $display("[TB] FAIL clamp_wrap: got q=%0d tc=%b wrap=%0d expected 0/1/1", q, tc, wrap_cnt); end
      tick();
      up_dn = 1'b0; ld_valid = 1'b1; ld_data = 4'd0;
      tick();
      ld_valid = 1'b0;
      tick();
      checks++; if (q !== 4'd0 || tc !== 1'b0 || wrap_cnt !== 8'd1) begin errors++; $display("[TB] FAIL load_zero: got q=%0d tc=%b wrap=%0d expected 0/0/1", q, tc, wrap_cnt); end
      tick();
      checks++; if (q !== 4'd9 || tc !== 1'b1 || wrap_cnt !== 8'd2) begin errors++; $display("[TB] FAIL down_after_load: got q=%0d tc=%b wrap=%0d expected 9/1/2", q, tc, wrap_cnt); end
   endtask

   task test_back_to_back();
      do_reset();
      ld_valid = 1'b1; ld_data = 4'd2;
      tick();
      ld_data = 4'd8;
      checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy: got ready=%b expected 0", ld_ready); end
      tick();
      checks++; if (q !== 4'd2 || ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got q=%0d ready=%b expected 2/1", q, ld_ready); end
      tick();
      ld_valid = 1'b0;
      tick();
      checks++; if (q !== 4'd8) begin errors++; $display("[TB] FAIL b2b_second: got q=%0d expected 8", q); end
      tick();
      checks++; if (q !== 4'd8 || j_vec !== 4'h0 || k_vec !== 4'h0) begin errors++; $display("[TB] FAIL idle_hold: got q=%0d j=%h k=%h expected 8/0/0", q, j_vec, k_vec); end
   endtask

   task test_async_reset();
      do_reset();
      en = 1'b1; up_dn = 1'b1;
      repeat (18) tick();
      checks++; if (q !== 4'd7 || wrap_cnt !== 8'd1) begin errors++; $display("[TB] FAIL pre_reset: got q=%0d wrap=%0d expected 7/1", q, wrap_cnt); end
      #2 rst = 1'b1;
      #1;
      checks++; if (q !== 4'd0 || q_bar !== 4'hF || wrap_cnt !== 8'd0) begin errors++; $display("[TB] FAIL async_reset: got q=%0d qb=%h wrap=%0d expected 0/f/0", q, q_bar, wrap_cnt); end
      rst = 1'b0; en = 1'b0;
      @(negedge clk);
      ld_valid = 1'b1; ld_data = 4'd6;
      tick();
      ld_valid = 1'b0;
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      tick();
      checks++; if (q !== 4'd0 || ld_ready !== 1'b1 || j_vec !== 4'h0) begin errors++; $display("[TB] FAIL reset_in_load: got q=%0d ready=%b j=%h expected 0/1/0", q, ld_ready, j_vec); end
   endtask

   task test_wrap_saturate();
      do_reset();
      en = 1'b1; up_dn = 1'b1;
      repeat (2601) tick();
      checks++; if (wrap_cnt !== 8'd255) begin errors++; $display("[TB] FAIL wrap_saturate: got %0d expected 255", wrap_cnt); end
   endtask

   task test_gray();
      logic [WIDTH-1:0] exp_seq [8];
      exp_seq = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4};
      do_reset();
      en = 1'b1; up_dn = 1'b1;
      tick();
      for (int i = 1; i < 8; i++) begin
         checks++; if ($countones(j_vec | k_vec) != 1 || (j_vec & k_vec) !== 4'h0) begin errors++; $display("[TB] FAIL gray_exc: got j=%b k=%b expected one bit", j_vec, k_vec); end
         tick();
         checks++; if (q !== exp_seq[i]) begin errors++; $display("[TB] FAIL gray_step: got q=%b expected %b", q, exp_seq[i]); end
      end
   endtask

   initial begin
      test_reset();
`ifdef JK_GRAY_CODE_EN
      test_gray();
`else
      test_count_up();
      test_count_down();
      test_load();
      test_back_to_back();
      test_async_reset();
      test_wrap_saturate();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
